prbs_checker: RTL and testbench

Serial PRBS checker: the receive end of the team's Fibonacci LFSR pattern generator. It self-synchronises to an incoming one-bit stream produced by a right-shifting LFSR of width 2–7 and declares lock after a run of correctly predicted bits. While locked, it counts bit errors and drops lock on a burst of consecutive mismatches. It sits on the lab bench next to the generator, in loopback or across a link, and reports link integrity through saturating counters.

---
 rtl/prbs_pkg.sv | 44 ++++
 rtl/prbs_checker_if.sv | 46 ++++
 rtl/prbs_sat_counter.sv | 34 +++
 rtl/prbs_checker.sv | 163 ++++++++++++++++
 tb/tb_prbs_checker.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg
// Definitions shared by the PRBS checker and the pattern generator that
// feeds it:
//   state_t   checker FSM states
//   tap_t     feedback tap pair (ta, tb) of the Fibonacci LFSR
//   tap_pair  maps an LFSR width (2..7) to its tap pair; the generator uses
//             the same function, so the two ends cannot disagree
//   DEF_*     default parameter values for the checker
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] ta;
    logic [2:0] tb;
  } tap_t;

  // Internal run/match/seed counters are a fixed 8 bits wide.
  typedef logic [7:0] cnt8_t;

  localparam int DEF_WIDTH      = 5;
  localparam int DEF_LOCK_COUNT = 8;
  localparam int DEF_ERR_LIMIT  = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  function automatic tap_t tap_pair(input int width);
    tap_t t;
    case (width)
      2:       t = '{ta: 3'd1, tb: 3'd0};
      3:       t = '{ta: 3'd2, tb: 3'd1};
      4:       t = '{ta: 3'd3, tb: 3'd2};
      5:       t = '{ta: 3'd4, tb: 3'd2};
      6:       t = '{ta: 3'd5, tb: 3'd4};
      7:       t = '{ta: 3'd6, tb: 3'd5};
      default: t = '{ta: 3'd4, tb: 3'd2};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if
// Serial receive bus of the PRBS checker plus its status/counter outputs.
//   din           received serial bit
//   din_valid     din is meaningful this cycle
//   clear_counts  zero the bit and error counters
//   locked        checker is locked to the incoming pattern
//   err_pulse     one-cycle pulse per locked-mode bit error
//   err_count     saturating count of locked-mode bit errors
//   bit_count     saturating count of bits consumed while locked
// modport master: the side that supplies bits (generator/link/bench)
// modport slave:  the checker
interface prbs_checker_if
  import prbs_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic                 din;
  logic                 din_valid;
  logic                 clear_counts;
  logic                 locked;
  logic                 err_pulse;
  logic [CNT_WIDTH-1:0] err_count;
  logic [CNT_WIDTH-1:0] bit_count;

  modport master (
    output din,
    output din_valid,
    output clear_counts,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  bit_count
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clear_counts,
    output locked,
    output err_pulse,
    output err_count,
    output bit_count
  );

endinterface

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    rising-edge clock
//   reset  synchronous active-high reset, q <= 0
//   clr    synchronous clear, wins over inc in the same cycle
//   inc    count up by one this cycle
//   q      registered count
module prbs_sat_counter
  import prbs_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= sat_inc(q);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
// Self-synchronising checker for the serial stream of a right-shifting
// Fibonacci LFSR (width 2..7). It fills a history register from the line,
// verifies LOCK_COUNT consecutive predicted bits, then free-runs on its own
// predictions and counts bits and errors. ERR_LIMIT consecutive errors while
// locked drop it back to seeding.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    prbs_checker_if.slave: din/din_valid/clear_counts in,
//          locked/err_pulse/err_count/bit_count out (all registered)
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_LIMIT  = DEF_ERR_LIMIT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input logic           clk,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam tap_t  TAPS      = tap_pair(WIDTH);
  localparam int    TA        = int'(TAPS.ta);
  localparam int    TB        = int'(TAPS.tb);
  localparam cnt8_t SEED_LAST = cnt8_t'(WIDTH - 1);
  localparam cnt8_t LOCK_LAST = cnt8_t'(LOCK_COUNT - 1);
  localparam cnt8_t ERR_LAST  = cnt8_t'(ERR_LIMIT - 1);

  state_t           state_p1, state_nxt;
  logic [WIDTH-1:0] hist_p1, hist_nxt;
  cnt8_t            seed_cnt_p1, seed_cnt_nxt;
  cnt8_t            match_cnt_p1, match_cnt_nxt;
  cnt8_t            run_cnt_p1, run_cnt_nxt;
  logic             locked_p1;
  logic             err_pulse_p1;
  logic             pred;
  logic             mismatch;
  logic             bit_inc;
  logic             err_inc;
  logic [CNT_WIDTH-1:0] err_count_q;
  logic [CNT_WIDTH-1:0] bit_count_q;

  // Stage p0: prediction, FSM next state, counter enables
  always_comb begin
    // hist holds the generator's current register image: hist[0] is the
    // oldest bit, so the tap XOR yields the next bit the generator emits.
    pred          = hist_p1[TA] ^ hist_p1[TB];
    mismatch      = bus.din ^ pred;
    state_nxt     = state_p1;
    hist_nxt      = hist_p1;
    seed_cnt_nxt  = seed_cnt_p1;
    match_cnt_nxt = match_cnt_p1;
    run_cnt_nxt   = run_cnt_p1;
    bit_inc       = 1'b0;
    err_inc       = 1'b0;

    if (bus.din_valid) begin
      unique case (state_p1)
        SEED: begin
          hist_nxt = {bus.din, hist_p1[WIDTH-1:1]};
          if (seed_cnt_p1 == SEED_LAST) begin
            seed_cnt_nxt = '0;
            // An all-zero window is the LFSR lock-up state; keep seeding so
            // a dead (stuck-at-0) line can never appear locked.
            if (hist_nxt != '0) begin
              state_nxt     = SYNC;
              match_cnt_nxt = '0;
            end
          end else begin
            seed_cnt_nxt = seed_cnt_p1 + cnt8_t'(1);
          end
        end

        SYNC: begin
          hist_nxt = {bus.din, hist_p1[WIDTH-1:1]};
          if (mismatch) begin
            state_nxt    = SEED;
            seed_cnt_nxt = '0;
          end else begin
            match_cnt_nxt = match_cnt_p1 + cnt8_t'(1);
            if (match_cnt_p1 == LOCK_LAST) begin
              state_nxt   = LOCKED;
              run_cnt_nxt = '0;
            end
          end
        end

        LOCKED: begin
          // Free-run on our own prediction so a single line error does not
          // corrupt the history and cascade into further errors.
          hist_nxt = {pred, hist_p1[WIDTH-1:1]};
          bit_inc  = 1'b1;
          if (mismatch) begin
            err_inc = 1'b1;
            if (run_cnt_p1 == ERR_LAST) begin
              state_nxt    = SEED;
              seed_cnt_nxt = '0;
              run_cnt_nxt  = '0;
            end else begin
              run_cnt_nxt = run_cnt_p1 + cnt8_t'(1);
            end
          end else begin
            run_cnt_nxt = '0;
          end
        end

        default: begin
          state_nxt    = SEED;
          seed_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Stage p1: state and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1     <= SEED;
      hist_p1      <= '0;
      seed_cnt_p1  <= '0;
      match_cnt_p1 <= '0;
      run_cnt_p1   <= '0;
      locked_p1    <= 1'b0;
      err_pulse_p1 <= 1'b0;
    end else begin
      state_p1     <= state_nxt;
      hist_p1      <= hist_nxt;
      seed_cnt_p1  <= seed_cnt_nxt;
      match_cnt_p1 <= match_cnt_nxt;
      run_cnt_p1   <= run_cnt_nxt;
      locked_p1    <= (state_nxt == LOCKED);
      err_pulse_p1 <= err_inc;
    end
  end

  prbs_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_counts),
    .inc   (err_inc),
    .q     (err_count_q)
  );

  prbs_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clear_counts),
    .inc   (bit_inc),
    .q     (bit_count_q)
  );

  assign bus.locked    = locked_p1;
  assign bus.err_pulse = err_pulse_p1;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: a WIDTH=5 instance with the default limits and
// a WIDTH=3, CNT_WIDTH=4, ERR_LIMIT=255 instance for counter saturation.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_WIDTH(16)) m_if ();
  prbs_checker_if #(.CNT_WIDTH(4))  s_if ();

  prbs_checker #(
    .WIDTH(5), .LOCK_COUNT(8), .ERR_LIMIT(4), .CNT_WIDTH(16)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  prbs_checker #(
    .WIDTH(3), .LOCK_COUNT(8), .ERR_LIMIT(255), .CNT_WIDTH(4)
  ) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.slave)
  );

  typedef struct {
    string tag;
    bit    sat;
    bit    locked;
    bit    errp;
    int    errc;
    int    bitc;
  } exp_t;

  typedef struct {
    string tag;
    int    n;       // cycles in this phase
    bit    gap;     // din_valid toggles 1010...
    int    ff;      // first consumed-bit index to invert (-1: none)
    int    fn;      // number of consecutive inverted bits
    bit    clr;     // clear_counts on the first cycle
    int    end_ec;  // err_count at end of phase
    int    end_bc;  // bit_count at end of phase
  } phase_t;

  exp_t   sbq[$];
  phase_t ph[8];
  int     checks = 0;
  int     failures = 0;
  logic [4:0] g5;
  logic [2:0] g3;
  int     ex_ec;
  int     ex_bc;

  function automatic exp_t mk(input string tag, input bit sat, input bit l,
                              input bit p, input int ec, input int bc);
    exp_t e;
    e.tag = tag; e.sat = sat; e.locked = l; e.errp = p; e.errc = ec; e.bitc = bc;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    logic l, p;
    int   ec, bc;
    e = sbq.pop_front();
    if (e.sat) begin
      l = s_if.locked; p = s_if.err_pulse;
      ec = int'(s_if.err_count); bc = int'(s_if.bit_count);
    end else begin
      l = m_if.locked; p = m_if.err_pulse;
      ec = int'(m_if.err_count); bc = int'(m_if.bit_count);
    end
    checks++;
    if (l !== e.locked || p !== e.errp || ec != e.errc || bc != e.bitc) begin
      failures++;
      $display("FAIL %s: got locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d, expected %0b %0b %0d %0d",
               e.tag, l, p, ec, bc, e.locked, e.errp, e.errc, e.bitc);
    end
  endtask

  // Drive one clock cycle on the selected checker, queue its expected
  // outputs, then compare once the edge has been consumed.
  task automatic cyc(input bit sat, input bit rst, input bit v, input bit fl,
                     input bit zero, input bit clr, input exp_t e);
    bit b;
    b = 1'($urandom_range(0, 1));
    if (v) begin
      if (zero) begin
        b = 1'b0;
      end else if (sat) begin
        b  = g3[0];
        g3 = {g3[2] ^ g3[1], g3[2:1]};
        b  = b ^ fl;
      end else begin
        b  = g5[0];
        g5 = {g5[4] ^ g5[2], g5[4:1]};
        b  = b ^ fl;
      end
    end
    reset = rst;
    m_if.din = 1'b0; m_if.din_valid = 1'b0; m_if.clear_counts = 1'b0;
    s_if.din = 1'b0; s_if.din_valid = 1'b0; s_if.clear_counts = 1'b0;
    if (sat) begin
      s_if.din = b; s_if.din_valid = v; s_if.clear_counts = clr;
    end else begin
      m_if.din = b; m_if.din_valid = v; m_if.clear_counts = clr;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    ph[0] = '{"clean",     100, 1'b0, -1, 0, 1'b0, 0, 100};
    ph[1] = '{"single",     20, 1'b0,  5, 1, 1'b0, 1, 120};
    ph[2] = '{"triple",     20, 1'b0,  3, 3, 1'b0, 4, 140};
    ph[3] = '{"double",     30, 1'b0, 10, 2, 1'b0, 6, 170};
    ph[4] = '{"gappy",      40, 1'b1, -1, 0, 1'b0, 6, 190};
    ph[5] = '{"gappy_err",  40, 1'b1,  4, 1, 1'b0, 7, 210};
    ph[6] = '{"clr",        10, 1'b0, -1, 0, 1'b1, 0, 9};
    ph[7] = '{"clr_err",     5, 1'b0,  0, 1, 1'b1, 0, 4};

    reset = 1'b1;
    m_if.din = 1'b0; m_if.din_valid = 1'b0; m_if.clear_counts = 1'b0;
    s_if.din = 1'b0; s_if.din_valid = 1'b0; s_if.clear_counts = 1'b0;
    g5 = 5'b00001;
    g3 = 3'b110;

    // Reset state of both instances
    cyc(0, 1, 0, 0, 0, 0, mk("reset_main", 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 0, mk("reset_sat", 1, 0, 0, 0, 0));

    // Clean lock from seed 00001: locked after exactly 13 consumed bits
    g5 = 5'b00001;
    for (int k = 1; k <= 13; k++)
      cyc(0, 0, 1, 0, 0, 0, mk("lock_clean", 0, k == 13, 0, 0, 0));
    for (int k = 1; k <= 1000; k++)
      cyc(0, 0, 1, 0, 0, 0, mk("run1000", 0, 1, 0, 0, k));

    // Reset while locked, with a valid bit on the line
    cyc(0, 1, 1, 0, 0, 0, mk("reset_locked", 0, 0, 0, 0, 0));

    // All-zero stream never locks
    for (int k = 1; k <= 500; k++)
      cyc(0, 0, 1, 0, 1, 0, mk("zeros", 0, 0, 0, 0, 0));

    // Relock on a non-degenerate seed, then the phase table
    cyc(0, 1, 0, 0, 0, 0, mk("reset_relock", 0, 0, 0, 0, 0));
    g5 = 5'b10111;
    for (int k = 1; k <= 13; k++)
      cyc(0, 0, 1, 0, 0, 0, mk("lock_seed2", 0, k == 13, 0, 0, 0));
    ex_ec = 0;
    ex_bc = 0;
    for (int i = 0; i < 8; i++) begin
      int cons;
      bit v, fl, cl;
      cons = 0;
      for (int c = 0; c < ph[i].n; c++) begin
        v  = ph[i].gap ? (c % 2 == 0) : 1'b1;
        fl = v && (cons >= ph[i].ff) && (cons < ph[i].ff + ph[i].fn);
        cl = ph[i].clr && (c == 0);
        if (v) begin
          ex_bc++;
          if (fl) ex_ec++;
        end
        if (cl) begin
          ex_bc = 0;
          ex_ec = 0;
        end
        cyc(0, 0, v, fl, 0, cl, mk(ph[i].tag, 0, 1, fl, ex_ec, ex_bc));
        if (v) cons++;
      end
      checks++;
      if (int'(m_if.err_count) != ph[i].end_ec || int'(m_if.bit_count) != ph[i].end_bc) begin
        failures++;
        $display("FAIL %s_end: got err_count=%0d bit_count=%0d, expected %0d %0d",
                 ph[i].tag, m_if.err_count, m_if.bit_count, ph[i].end_ec, ph[i].end_bc);
      end
    end

    // Error burst of ERR_LIMIT=4 drops lock on the 4th; relock after 13
    for (int k = 1; k <= 4; k++) begin
      ex_bc++;
      ex_ec++;
      cyc(0, 0, 1, 1, 0, 0, mk("burst", 0, k < 4, 1, ex_ec, ex_bc));
    end
    for (int k = 1; k <= 13; k++)
      cyc(0, 0, 1, 0, 0, 0, mk("relock", 0, k == 13, 0, ex_ec, ex_bc));
    for (int k = 1; k <= 5; k++) begin
      ex_bc++;
      cyc(0, 0, 1, 0, 0, 0, mk("after_relock", 0, 1, 0, ex_ec, ex_bc));
    end

    // Gappy valid with a fault during SYNC: lock 13 consumed bits later
    cyc(0, 1, 0, 0, 0, 0, mk("reset_gap", 0, 0, 0, 0, 0));
    g5 = 5'b10111;
    ex_bc = 0;
    begin
      int cons, post;
      bit lk, v, fl;
      cons = 0;
      post = -1;
      lk = 1'b0;
      for (int c = 0; c < 80; c++) begin
        v  = (c % 2 == 0);
        fl = v && (cons == 7);
        if (v) begin
          if (lk) ex_bc++;
          if (post >= 0) begin
            post++;
            if (post == 13) lk = 1'b1;
          end
          if (fl) post = 0;
          cons++;
        end
        cyc(0, 0, v, fl, 0, 0, mk("gap_sync", 0, lk, 0, 0, ex_bc));
      end
    end

    // Saturation at 15 with an error on every bit, then clear vs increment
    cyc(1, 1, 0, 0, 0, 0, mk("reset_sat2", 1, 0, 0, 0, 0));
    g3 = 3'b110;
    for (int k = 1; k <= 11; k++)
      cyc(1, 0, 1, 0, 0, 0, mk("sat_lock", 1, k == 11, 0, 0, 0));
    for (int k = 1; k <= 20; k++)
      cyc(1, 0, 1, 1, 0, 0, mk("sat_err", 1, 1, 1, (k > 15) ? 15 : k, (k > 15) ? 15 : k));
    cyc(1, 0, 1, 1, 0, 1, mk("sat_clr_err", 1, 1, 1, 0, 0));
    cyc(1, 0, 1, 1, 0, 0, mk("sat_err_after_clr", 1, 1, 1, 1, 1));
    cyc(1, 0, 1, 0, 0, 0, mk("sat_clean", 1, 1, 0, 1, 2));
    cyc(1, 1, 1, 1, 0, 0, mk("sat_reset_locked", 1, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      cyc(1, 0, 0, 0, 0, 0, mk("sat_post_reset", 1, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
